vgatest_sequencer: RTL and testbench
====================================

# vgatest_sequencer

Frame-synchronous controller for the VGA test-pattern generator. It takes the vertical sync from the sync generator and two raw push-buttons. It decides which test pattern the pattern datapath draws, and changes the selection only at a frame boundary so no frame shows two patterns. With the auto-cycle feature it also steps through patterns on a frame count.

## Interface
Parameters:
- NUM_PATTERNS, 4: number of patterns; legal 2..8; index wraps NUM_PATTERNS-1 -> 0.
- FRAMES_PER_PATTERN, 120: frames shown per pattern in auto mode; legal 1..255.
- DEBOUNCE_BITS, 16: debounce counter width; input must be stable 2^DEBOUNCE_BITS-1 cycles.
- VS_POL, 1: active level of vs (1 = positive sync, as for 800x600).

Ports:
- clk  in  1  pixel clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- vs  in  1  vertical sync from the sync generator; treated as asynchronous.
- btn_next  in  1  raw button, active-high; requests next pattern.
- btn_mode  in  1  raw button, active-high; toggles manual/auto.
- pattern  out  3  current pattern index; reset 0.
- advance  out  1  one-cycle pulse, high in the cycle pattern takes a new value; reset 0.
- frame_start  out  1  one-cycle pulse per frame; reset 0.
- auto_mode  out  1  high in ST_AUTO; reset 0.

## Operation
- vs, btn_next and btn_mode each pass through a 2-FF synchronizer.
- Debounce, per button: the counter clears whenever the synced input equals the debounced state. It increments while they differ. At all-ones it loads the debounced state and clears. A debounced 0->1 transition gives a one-cycle press pulse.
- frame_start: synced vs goes from inactive to the VS_POL level.
- States:
  - ST_MANUAL is the reset state.
  - ST_AUTO exists only with the macro.
  - A mode press toggles between them.
  - Entering ST_AUTO clears frame_cnt.
- next_pend flag:
  - A next press sets it.
  - Any number of presses within one frame collapse to a single advance.
  - It clears when an advance occurs.
- Advance condition: frame_start && (next_pend || next press this cycle || auto_due).
  - auto_due = ST_AUTO && frame_cnt == FRAMES_PER_PATTERN-1.
- On an advance:
  - pattern <= (pattern == NUM_PATTERNS-1) ? 0 : pattern+1.
  - advance pulses.
  - frame_cnt clears.
- On frame_start without an advance, in ST_AUTO: frame_cnt increments (8 bits).
- A manual advance in ST_AUTO restarts the frame count, so the next auto step is FRAMES_PER_PATTERN frames later.
- Mode press and frame_start in the same cycle: the toggle takes effect first. The frame_start is evaluated with the old state, and frame_cnt is cleared if entering ST_AUTO.
- rst_n low at any time asynchronously clears all registers, including synchronizers, debounce state, next_pend and frame_cnt. Debounced button states reset to 0.

## Timing
- frame_start is high in the 3rd clk cycle after the first rising edge that samples vs at its active level: 2 sync FFs plus the edge register.
- pattern and advance update on the clk edge that ends the frame_start cycle. They are visible one cycle after frame_start, well inside vertical blanking.
- Button press latency: 2 sync cycles, plus 2^DEBOUNCE_BITS-1 stable cycles, plus 1 edge cycle, to the press pulse. The pattern then changes at the next frame_start.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- PATTERN_AUTOCYCLE_EN defined:
  - ST_AUTO, frame_cnt and the btn_mode debouncer are built.
  - Behaviour is as above.
- Undefined:
  - Only ST_MANUAL exists.
  - btn_mode is ignored, with no debouncer instantiated.
  - auto_mode is tied 0.
  - frame_cnt and FRAMES_PER_PATTERN are unused.
  - Patterns change only on btn_next.

## Structure
- Package vgatest_pkg holds:
  - state encoding ST_MANUAL=1'b0, ST_AUTO=1'b1;
  - PAT_W=3;
  - FCNT_W=8.
- Sub-module vgatest_debounce (synchronizer + debounce counter + press pulse, parameterised by DEBOUNCE_BITS) is instantiated once per button.
- vs has its own 2-FF synchronizer and edge detect in the top level.

## Test plan
The bench uses DEBOUNCE_BITS=4, NUM_PATTERNS=4, FRAMES_PER_PATTERN=3 and the macro defined, unless a line says otherwise.
- Reset, then 5 vs pulses with no buttons -> pattern stays 0, 5 frame_start pulses each 3 cycles after vs rises, advance never high.
- btn_next held 20 cycles mid-frame with a 3-cycle glitch before it -> only one advance, at the next frame_start, pattern 0->1; the glitch alone causes no press.
- Three separate next presses in one frame, then 4 more single presses in later frames -> first frame advances once (0->1), then 1->2->3->0, with the wrap checked.
- Mode press, then 7 frames -> auto_mode=1, advances at the 3rd and 6th frame_start after entry; a manual press before frame 8 advances there and restarts the 3-frame count.
- Macro undefined, btn_mode pressed, 10 frames -> auto_mode=0 and pattern unchanged.
- rst_n pulsed low mid-frame with next_pend set and pattern=2 -> outputs 0 immediately; the next frame_start causes no advance.

Source files
------------

// File: rtl/vgatest_pkg.sv
// rtl/vgatest_pkg.sv - shared types, widths and helpers for the VGA test-pattern sequencer
package vgatest_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    localparam int PAT_W  = 3;
    localparam int FCNT_W = 8;

    // Next pattern index with wrap from the last legal index back to 0.
    function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] cur,
                                                      input int num_patterns);
        return (cur == PAT_W'(num_patterns - 1)) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/vgatest_sequencer_if.sv
// rtl/vgatest_sequencer_if.sv - sync/button inputs and pattern-select outputs of the sequencer
interface vgatest_sequencer_if;
    import vgatest_pkg::*;

    logic             vs;
    logic             btn_next;
    logic             btn_mode;
    logic [PAT_W-1:0] pattern;
    logic             advance;
    logic             frame_start;
    logic             auto_mode;

    // The sequencer drives the pattern selection and consumes sync/buttons.
    modport master (
        input  vs, btn_next, btn_mode,
        output pattern, advance, frame_start, auto_mode
    );

    // The pattern datapath / environment side.
    modport slave (
        output vs, btn_next, btn_mode,
        input  pattern, advance, frame_start, auto_mode
    );

endinterface

// File: rtl/vgatest_debounce.sv
// rtl/vgatest_debounce.sv - 2-FF synchronizer, debounce counter and press pulse for one button
module vgatest_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic press_o
);

    logic                     sync1_q;
    logic                     sync2_q;
    logic                     state_q, state_d;
    logic                     press_q, press_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    // Count while the synced input disagrees with the debounced state; accept at all-ones.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        press_d = 1'b0;
        if (sync2_q != state_q) begin
            if (&cnt_q) begin
                state_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vgatest_sequencer.sv
// rtl/vgatest_sequencer.sv - frame-synchronous test-pattern selector; PATTERN_AUTOCYCLE_EN builds auto-cycle mode
module vgatest_sequencer
    import vgatest_pkg::*;
#(
    parameter int NUM_PATTERNS       = 4,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int DEBOUNCE_BITS      = 16,
    parameter int VS_POL             = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vgatest_sequencer_if.master  ifc
);

    localparam logic VS_ACT = (VS_POL != 0);

    logic             vs_sync1_q;
    logic             vs_sync2_q;
    logic             vs_prev_q;
    logic             frame_start_q, frame_start_d;
    logic             next_press;
    logic             next_pend_q, next_pend_d;
    logic             advance_q, advance_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             auto_due;

    vgatest_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_next_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (ifc.btn_next),
        .press_o (next_press)
    );

    // Frame boundary: synced vs just reached its active level.
    assign frame_start_d = (vs_sync2_q == VS_ACT) && (vs_prev_q != VS_ACT);

    // vs synchronizer and edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync1_q    <= 1'b0;
            vs_sync2_q    <= 1'b0;
            vs_prev_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vs_sync1_q    <= ifc.vs;
            vs_sync2_q    <= vs_sync1_q;
            vs_prev_q     <= vs_sync2_q;
            frame_start_q <= frame_start_d;
        end
    end

    // Advance only on a frame boundary; presses within a frame collapse into one pending request.
    always_comb begin
        advance_d   = frame_start_q && (next_pend_q || next_press || auto_due);
        pattern_d   = pattern_q;
        next_pend_d = next_pend_q;
        if (advance_d) begin
            pattern_d   = next_pattern(pattern_q, NUM_PATTERNS);
            next_pend_d = 1'b0;
        end else if (next_press) begin
            next_pend_d = 1'b1;
        end
    end

    // Pattern selection registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q   <= '0;
            advance_q   <= 1'b0;
            next_pend_q <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            advance_q   <= advance_d;
            next_pend_q <= next_pend_d;
        end
    end

`ifdef PATTERN_AUTOCYCLE_EN
    state_e            state_q, state_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              mode_press;

    vgatest_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_mode_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (ifc.btn_mode),
        .press_o (mode_press)
    );

    // Auto step is judged against the state before any same-cycle mode toggle.
    assign auto_due = (state_q == ST_AUTO) &&
                      (frame_cnt_q == FCNT_W'(FRAMES_PER_PATTERN - 1));

    // Mode FSM next state and frame counter; entering auto restarts the count.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (mode_press) begin
            state_d = (state_q == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
        end
        if (mode_press && (state_q == ST_MANUAL)) begin
            frame_cnt_d = '0;
        end else if (advance_d) begin
            frame_cnt_d = '0;
        end else if (frame_start_q && (state_q == ST_AUTO)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Mode state and frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MANUAL;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ifc.auto_mode = (state_q == ST_AUTO);
`else
    logic              unused_mode;
    logic [FCNT_W-1:0] unused_fpp;

    assign unused_mode   = ifc.btn_mode;
    assign unused_fpp    = FCNT_W'(FRAMES_PER_PATTERN);
    assign auto_due      = 1'b0;
    assign ifc.auto_mode = 1'b0;
`endif

    assign ifc.pattern     = pattern_q;
    assign ifc.advance     = advance_q;
    assign ifc.frame_start = frame_start_q;

endmodule

// File: tb/tb_vgatest_sequencer.sv
// tb/tb_vgatest_sequencer.sv - self-checking bench for vgatest_sequencer
module tb_vgatest_sequencer;
    import vgatest_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vgatest_sequencer_if ifc ();

    vgatest_sequencer #(
        .NUM_PATTERNS       (4),
        .FRAMES_PER_PATTERN (3),
        .DEBOUNCE_BITS      (4),
        .VS_POL             (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    int               n_cmp = 0;
    int               n_err = 0;
    logic [PAT_W-1:0] exp_q[$];
    logic [PAT_W-1:0] mon_exp;

    // Reference model state
    int m_pat  = 0;
    bit m_pend = 1'b0;
    bit m_auto = 1'b0;
    int m_fcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Every advance pulse must match the next queued expected pattern.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.advance === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_advance observed pattern=%0d expected no advance", ifc.pattern);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                n_cmp++;
                assert (ifc.pattern === mon_exp) else begin
                    n_err++;
                    $error("FAIL advance_pattern observed=%0d expected=%0d", ifc.pattern, mon_exp);
                end
            end
        end
    end

    // One vs pulse; model decides beforehand whether this frame advances.
    task automatic frame(input string tag);
        int lat = 0;
        int nfs = 0;
        if (m_pend || (m_auto && m_fcnt == 2)) begin
            m_pat  = (m_pat == 3) ? 0 : m_pat + 1;
            exp_q.push_back(PAT_W'(m_pat));
            m_pend = 1'b0;
            m_fcnt = 0;
        end else if (m_auto) begin
            m_fcnt++;
        end
        ifc.vs = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ifc.frame_start === 1'b1) begin
                nfs++;
                if (lat == 0) lat = k;
            end
        end
        ifc.vs = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_fs_latency"}, lat, 3);
        chk({tag, "_fs_count"}, nfs, 1);
        chk({tag, "_pattern"}, ifc.pattern, m_pat);
        chk({tag, "_advances_pending"}, exp_q.size(), 0);
        chk({tag, "_auto_mode"}, ifc.auto_mode, m_auto);
    endtask

    task automatic press_next();
        ifc.btn_next = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ifc.btn_next = 1'b0;
        m_pend = 1'b1;
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        ifc.btn_mode = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ifc.btn_mode = 1'b0;
`ifdef PATTERN_AUTOCYCLE_EN
        m_auto = !m_auto;
        if (m_auto) m_fcnt = 0;
`endif
        repeat (25) @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.vs       = 1'b0;
        ifc.btn_next = 1'b0;
        ifc.btn_mode = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pattern", ifc.pattern, 0);
        chk("reset_advance", ifc.advance, 0);
        chk("reset_frame_start", ifc.frame_start, 0);
        chk("reset_auto_mode", ifc.auto_mode, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Idle frames: no buttons, no advances
        for (int i = 0; i < 5; i++) frame("idle");

        // Short glitch must not register as a press
        ifc.btn_next = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ifc.btn_next = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        frame("glitch");

        // Held press advances once at the next frame
        press_next();
        frame("held_press");

        // Three presses in one frame collapse to one advance, then single steps with wrap
        press_next();
        press_next();
        press_next();
        frame("multi_press");
        for (int i = 0; i < 4; i++) begin
            press_next();
            frame("step_wrap");
        end

`ifdef PATTERN_AUTOCYCLE_EN
        // Auto mode: step every third frame; manual press restarts the count
        press_mode();
        chk("auto_entered", ifc.auto_mode, 1);
        for (int i = 0; i < 7; i++) frame("auto");
        press_next();
        frame("auto_manual");
        for (int i = 0; i < 3; i++) frame("auto_restart");
        press_mode();
        chk("auto_left", ifc.auto_mode, 0);
        frame("manual_again");
`else
        // Mode button is ignored in this build
        press_mode();
        for (int i = 0; i < 10; i++) frame("mode_ignored");
`endif

        // Bring pattern to 2, leave a request pending, then reset mid-frame
        for (int i = 0; i < 4 && m_pat != 2; i++) begin
            press_next();
            frame("to_two");
        end
        chk("before_reset_pattern", ifc.pattern, 2);
        press_next();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_reset_pattern", ifc.pattern, 0);
        chk("async_reset_advance", ifc.advance, 0);
        chk("async_reset_auto_mode", ifc.auto_mode, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_pat  = 0;
        m_pend = 1'b0;
        m_auto = 1'b0;
        m_fcnt = 0;
        frame("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
